// File: rtl/pulse_decoder.sv
// rtl/pulse_decoder.sv - counts rising edges in a pulse burst delimited by a run of low samples
module pulse_decoder #(
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  // GAP_CYCLES never exceeds 15, so four bits always hold the gap run length
  localparam int GAP_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state, state_n;
  logic             prev;
  logic [CNT_W-1:0] pcnt, pcnt_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic             ovf_flag, ovf_flag_n;
  logic [CNT_W-1:0] count_n;
  logic             overflow_n;
  logic             valid_n;
  logic             rise;

  // a level held high is one pulse: only the low-to-high transition counts
  assign rise = signal & ~prev;

  // state register plus all counters and the registered result outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      prev     <= 1'b0;
      pcnt     <= '0;
      gap      <= '0;
      ovf_flag <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      prev     <= signal;
      pcnt     <= pcnt_n;
      gap      <= gap_n;
      ovf_flag <= ovf_flag_n;
      count    <= count_n;
      overflow <= overflow_n;
      valid    <= valid_n;
      busy     <= (state_n == BURST);
    end
  end

  // next-state, pulse/gap counting and burst completion
  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    gap_n      = gap;
    ovf_flag_n = ovf_flag;
    count_n    = count;
    overflow_n = overflow;
    valid_n    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n    = BURST;
          pcnt_n     = CNT_W'(1);
          gap_n      = '0;
          ovf_flag_n = 1'b0;
        end
      end
      BURST: begin
        if (rise) begin
          if (pcnt == CNT_MAX) begin
            ovf_flag_n = 1'b1;
          end else begin
            pcnt_n = pcnt + CNT_W'(1);
          end
        end
        if (signal) begin
          gap_n = '0;
        end else if (gap == GAP_LAST) begin
          // this sample completes the gap: publish the burst and rearm
          count_n    = pcnt;
          overflow_n = ovf_flag;
          valid_n    = 1'b1;
          gap_n      = '0;
          state_n    = IDLE;
        end else begin
          gap_n = gap + GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pulse_decoder.sv
// tb/tb_pulse_decoder.sv - scoreboard bench for pulse_decoder
module tb_pulse_decoder;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             signal;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             overflow;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // expected {overflow, count} for every burst that must complete
  logic [CNT_W:0] sb[$];

  pulse_decoder #(.GAP_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .signal  (signal),
    .count   (count),
    .valid   (valid),
    .overflow(overflow),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  // every valid cycle consumes exactly one expected result
  always @(negedge clock) begin
    logic [CNT_W:0] exp;
    if (valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid count=%0d overflow=%0d expected no valid", count, overflow);
      end else begin
        exp = sb.pop_front();
        if ({overflow, count} !== exp) begin
          failures++;
          $display("FAIL sb_result got ovf=%0d count=%0d expected ovf=%0d count=%0d",
                   overflow, count, exp[CNT_W], exp[CNT_W-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v);
    signal = v;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    signal = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({count, valid, overflow, busy} !== {{CNT_W{1'b0}}, 3'b000}) begin
      failures++;
      $display("FAIL reset_state got count=%0d valid=%0d ovf=%0d busy=%0d expected all 0",
               count, valid, overflow, busy);
    end
    reset = 1'b0;
    drive(1'b0);
  endtask

  task automatic test_basic();
    sb.push_back({1'b0, 4'd2});
    drive(1'b1); drive(1'b0); drive(1'b1);
    drive(1'b0); drive(1'b0); drive(1'b0);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_before_gap got valid=%0d busy=%0d expected valid=0 busy=1", valid, busy);
    end
    drive(1'b0);
    checks++;
    if (valid !== 1'b1 || count !== 4'd2 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got valid=%0d count=%0d ovf=%0d busy=%0d expected 1 2 0 0",
               valid, count, overflow, busy);
    end
    drive(1'b0);
    checks++;
    if (valid !== 1'b0 || count !== 4'd2) begin
      failures++;
      $display("FAIL basic_hold got valid=%0d count=%0d expected valid=0 count=2", valid, count);
    end
    drive(1'b0);
  endtask

  task automatic test_overflow();
    sb.push_back({1'b1, 4'd15});
    for (int i = 0; i < 17; i++) begin
      drive(1'b1);
      drive(1'b0);
    end
    drive(1'b0); drive(1'b0); drive(1'b0);
    checks++;
    if (valid !== 1'b1 || count !== 4'd15 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_result got valid=%0d count=%0d ovf=%0d expected 1 15 1",
               valid, count, overflow);
    end
    drive(1'b0);
  endtask

  task automatic test_gap3();
    int bad_busy = 0;
    sb.push_back({1'b0, 4'd5});
    for (int p = 0; p < 5; p++) begin
      drive(1'b1);
      if (busy !== 1'b1 || valid !== 1'b0) bad_busy++;
      if (p < 4) begin
        for (int k = 0; k < 3; k++) begin
          drive(1'b0);
          if (busy !== 1'b1 || valid !== 1'b0) bad_busy++;
        end
      end
    end
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL gap3_busy got %0d samples with busy low or valid high expected 0", bad_busy);
    end
    drive(1'b0); drive(1'b0); drive(1'b0); drive(1'b0);
    checks++;
    if (valid !== 1'b1 || count !== 4'd5 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL gap3_result got valid=%0d count=%0d ovf=%0d expected 1 5 0", valid, count, overflow);
    end
    drive(1'b0);
  endtask

  task automatic test_long_high();
    sb.push_back({1'b0, 4'd1});
    repeat (10) drive(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL long_high_busy got busy=%0d expected 1", busy);
    end
    repeat (4) drive(1'b0);
    checks++;
    if (valid !== 1'b1 || count !== 4'd1) begin
      failures++;
      $display("FAIL long_high_result got valid=%0d count=%0d expected 1 1", valid, count);
    end
    drive(1'b0);
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b0); drive(1'b1);
    reset  = 1'b1;
    signal = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || count !== 4'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear got busy=%0d count=%0d valid=%0d expected 0 0 0", busy, count, valid);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0);
      if (valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_mid_no_valid got %0d valid cycles expected 0", stray);
    end
    sb.push_back({1'b0, 4'd2});
    drive(1'b1); drive(1'b0); drive(1'b1);
    repeat (4) drive(1'b0);
    checks++;
    if (valid !== 1'b1 || count !== 4'd2) begin
      failures++;
      $display("FAIL reset_mid_new_burst got valid=%0d count=%0d expected 1 2", valid, count);
    end
    drive(1'b0);
  endtask

  task automatic test_high_at_reset();
    sb.push_back({1'b0, 4'd1});
    reset  = 1'b1;
    signal = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL high_at_reset_rise got busy=%0d expected 1", busy);
    end
    drive(1'b1);
    repeat (4) drive(1'b0);
    checks++;
    if (valid !== 1'b1 || count !== 4'd1) begin
      failures++;
      $display("FAIL high_at_reset_result got valid=%0d count=%0d expected 1 1", valid, count);
    end
    drive(1'b0);
  endtask

  task automatic test_back_to_back();
    sb.push_back({1'b0, 4'd1});
    sb.push_back({1'b0, 4'd2});
    drive(1'b1);
    repeat (4) drive(1'b0);
    checks++;
    if (valid !== 1'b1 || count !== 4'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first got valid=%0d count=%0d busy=%0d expected 1 1 0", valid, count, busy);
    end
    drive(1'b1);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart got valid=%0d busy=%0d expected 0 1", valid, busy);
    end
    drive(1'b0); drive(1'b1);
    repeat (4) drive(1'b0);
    checks++;
    if (valid !== 1'b1 || count !== 4'd2) begin
      failures++;
      $display("FAIL b2b_second got valid=%0d count=%0d expected 1 2", valid, count);
    end
    drive(1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    signal = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_gap3();
    test_long_high();
    test_reset_mid();
    test_high_at_reset();
    test_back_to_back();
    repeat (3) drive(1'b0);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d results outstanding expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_decoder.md
PULSE_DECODER -- requirements
Module: pulse_decoder

Interface
REQ-001 Parameter GAP_CYCLES, default 4: number of consecutive low samples that terminates a burst; legal range 2..15.
REQ-002 Parameter CNT_W, default 4: width of the pulse counter and of output count.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 Port signal, input, 1: pulse-train input; synchronous to clock, sampled once per rising edge.
REQ-006 Port count, output, CNT_W: number of pulses in the last completed burst.
REQ-007 Port valid, output, 1: one-cycle strobe marking a completed burst result.
REQ-008 Port overflow, output, 1: set when the last completed burst exceeded 2^CNT_W-1 pulses.
REQ-009 Port busy, output, 1: high while a burst is being decoded.

Function
REQ-010 The block SHALL keep a register prev holding the signal value sampled at the previous edge; rise = signal & ~prev.
REQ-011 The block SHALL implement a two-state FSM, IDLE and BURST; busy = (state == BURST), registered.
REQ-012 In IDLE, on rise: go to BURST, pulse counter = 1, gap counter = 0, overflow flag = 0; otherwise stay in IDLE.
REQ-013 In BURST, each rise SHALL increment the pulse counter, saturating at 2^CNT_W-1; a rise at saturation SHALL set the internal overflow flag.
REQ-014 In BURST, each sample with signal=1 SHALL clear the gap counter; each sample with signal=0 SHALL increment it.
REQ-015 On the edge that samples the GAP_CYCLES-th consecutive low in BURST, the block SHALL register count = pulse counter, overflow = overflow flag, valid = 1, and return to IDLE.
REQ-016 valid SHALL be high for exactly one clock cycle per completed burst; count and overflow SHALL hold until the next valid or reset.
REQ-017 A signal held high for any number of cycles SHALL count as one pulse; no timeout applies while high.
REQ-018 In the cycle valid is high, the FSM is in IDLE; a rise sampled on that cycle's closing edge SHALL start a new burst with no lost pulse.
REQ-019 Fewer than GAP_CYCLES consecutive lows between pulses SHALL NOT split a burst.

Reset
REQ-020 While reset is high at a rising edge: state=IDLE, prev=0, count=0, valid=0, overflow=0, busy=0, and internal counters cleared; reset takes priority over all other events.
REQ-021 Reset asserted mid-burst SHALL discard the burst; no valid SHALL be produced for it.
REQ-022 Because prev resets to 0, a signal already high on the first edge after reset release SHALL be detected as a rise.

Verification
REQ-023 Scenario: GAP_CYCLES=4. Pattern 1 high, 1 low, 1 high, then 6 low -> valid high for exactly one cycle, starting at the edge sampling the 4th low after the last high; count=2, overflow=0.
REQ-024 Scenario: 17 one-cycle pulses separated by single lows, then 4 lows -> count=15, overflow=1, one valid.
REQ-025 Scenario: pulses separated by exactly 3 lows (GAP_CYCLES=4), 5 pulses, then 4 lows -> a single valid with count=5; busy stays high throughout the burst.
REQ-026 Scenario: signal high for 10 cycles, then low for 4 -> count=1, valid once.
REQ-027 Scenario: reset pulsed for 1 cycle after 3 pulses of a burst -> busy=0 and count=0 on the next cycle; no valid until a new burst completes.
REQ-028 Scenario: signal=1 while reset deasserts, held for 2 cycles, then low for 4 -> count=1, valid once.
